// File: rtl/palette_pkg.sv
// Shared types and constants for the NES palette download path.
package palette_pkg;

  localparam int unsigned PAL_ENTRIES         = 64;
  localparam int unsigned PAL_BYTES_PER_ENTRY = 3;

  typedef struct packed {
    logic [5:0]  idx;
    logic [23:0] rgb;
  } pal_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN
  } pal_ld_state_t;

endpackage

// File: rtl/pal_fifo.sv
// Synchronous FIFO of palette entries with flush; a push into a full FIFO
// is taken only when a pop frees a slot in the same cycle.
module pal_fifo
  import palette_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  pal_entry_t    push_data,
  input  logic          pop,
  output pal_entry_t    pop_data,
  output logic [CW-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  pal_entry_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop   = pop && (count != '0);
  assign do_push  = push && ((count != CW'(DEPTH)) || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/palette_loader.sv
// Assembles downloaded R/G/B bytes into palette entries and writes them to
// the video palette RAM only while the display is blanked.
module palette_loader
  import palette_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ENTRIES    = PAL_ENTRIES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [7:0]  dl_addr,
  input  logic [7:0]  dl_data,
  input  logic        blank,
  output logic        dl_wait,
  output logic        load_color,
  output logic [5:0]  load_color_index,
  output logic [23:0] load_color_data,
  output logic        busy,
  output logic        done,
  output logic        overflow
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned IW = $clog2(ENTRIES) + 1;
  localparam logic [1:0]  LAST_COMP = 2'(PAL_BYTES_PER_ENTRY - 1);

  pal_ld_state_t state, next_state;
  logic          active_q, dl_rise;
  logic          start, drain_done;
  logic [1:0]    comp, comp_eff;
  logic [IW-1:0] idx, idx_eff;
  logic [7:0]    r_q, g_q;
  logic          accept, restart, take;
  pal_entry_t    entry_q, fifo_head;
  logic          push_q, pop, drop;
  logic [CW-1:0] fifo_count;

  assign dl_rise = dl_active && !active_q;
  assign dl_wait = (fifo_count == CW'(FIFO_DEPTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (dl_rise) next_state = LOAD;
      LOAD:  if (!dl_active) next_state = DRAIN;
      DRAIN: begin
        if (dl_rise) next_state = LOAD;
        else if ((fifo_count == '0) && !push_q) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // A rise in DRAIN abandons the pending entries without a done pulse.
  always_comb begin
    start      = 1'b0;
    drain_done = 1'b0;
    case (state)
      IDLE:  start = dl_rise;
      DRAIN: begin
        start      = dl_rise;
        drain_done = !dl_rise && (fifo_count == '0) && !push_q;
      end
      default: ;
    endcase
  end

  assign accept   = dl_wr && dl_active && ((state == LOAD) || start);
  assign restart  = start || (dl_addr == 8'd0);
  assign comp_eff = restart ? 2'd0 : comp;
  assign idx_eff  = restart ? '0 : idx;
  assign take     = accept && (idx_eff < IW'(ENTRIES));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q <= 1'b0;
      comp     <= '0;
      idx      <= '0;
      r_q      <= '0;
      g_q      <= '0;
      entry_q  <= '0;
      push_q   <= 1'b0;
    end else begin
      active_q <= dl_active;
      push_q   <= 1'b0;
      if (take) begin
        case (comp_eff)
          2'd0: r_q <= dl_data;
          2'd1: g_q <= dl_data;
          default: begin
            entry_q.idx <= 6'(idx_eff);
            entry_q.rgb <= {r_q, g_q, dl_data};
            push_q      <= 1'b1;
          end
        endcase
        comp <= (comp_eff == LAST_COMP) ? 2'd0 : comp_eff + 2'd1;
        idx  <= (comp_eff == LAST_COMP) ? idx_eff + IW'(1) : idx_eff;
      end else if (start) begin
        comp <= '0;
        idx  <= '0;
      end
    end
  end

  assign pop  = (fifo_count != '0) && blank && !start;
  assign drop = push_q && (fifo_count == CW'(FIFO_DEPTH)) && !pop;

  pal_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (start),
    .push      (push_q),
    .push_data (entry_q),
    .pop       (pop),
    .pop_data  (fifo_head),
    .count     (fifo_count)
  );

  // Palette RAM port and status; index/data hold after the strobe drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_color       <= 1'b0;
      load_color_index <= '0;
      load_color_data  <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      overflow         <= 1'b0;
    end else begin
      load_color <= pop;
      if (pop) begin
        load_color_index <= fifo_head.idx;
        load_color_data  <= fifo_head.rgb;
      end
      busy <= (next_state != IDLE);
      done <= drain_done;
      if (start)     overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;
    end
  end

endmodule
